// File: rtl/cva6_dmr_resync_ctrl.sv
// DMR recovery sequencer for the CVA6 hart cluster: setback window,
// sync wait with bounded retries, sticky failure and mismatch counter.
module cva6_dmr_resync_ctrl #(
  parameter int unsigned NumHarts      = 2,
  parameter int unsigned SetbackCycles = 4,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned MaxRetries    = 2,
  parameter int unsigned CntWidth      = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                redundancy_en_i,
  input  logic [NumHarts-1:0] dmr_error_i,
  input  logic                sw_resync_req_i,
  input  logic [NumHarts-1:0] harts_sync_req_i,
  input  logic                fail_clear_i,
  input  logic                cnt_clear_i,
  output logic [NumHarts-1:0] core_setback_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic                fail_o,
  output logic [CntWidth-1:0] err_cnt_o
);

  localparam int unsigned SbW =
    SetbackCycles > 1 ? $clog2(SetbackCycles) : 1;
  localparam int unsigned ToW =
    TimeoutCycles > 1 ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned RtW =
    MaxRetries > 0 ? $clog2(MaxRetries + 1) : 1;

  typedef enum logic [1:0] {
    Idle,
    Setback,
    WaitSync,
    Failed
  } state_e;

  state_e           state_q, state_d;
  logic [SbW-1:0]   sb_cnt_q, sb_cnt_d;
  logic [ToW-1:0]   timer_q, timer_d;
  logic [RtW-1:0]   retry_q, retry_d;
  logic             done_d, timeout_d;
  logic             err_or, err_prev_q, err_edge;
  logic             trigger, synced;
  logic [CntWidth-1:0] cnt_q;

  assign err_or   = |dmr_error_i;
  assign err_edge = err_or & ~err_prev_q;
  assign trigger  = redundancy_en_i & (err_or | sw_resync_req_i);
  assign synced   = &harts_sync_req_i;

  always_comb begin
    state_d   = state_q;
    sb_cnt_d  = sb_cnt_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      Idle: begin
        if (trigger) begin
          state_d  = Setback;
          sb_cnt_d = SbW'(SetbackCycles - 1);
          retry_d  = '0;
        end
      end
      Setback: begin
        if (!redundancy_en_i) begin
          state_d = Idle;
        end else if (sb_cnt_q == '0) begin
          state_d = WaitSync;
          timer_d = '0;
        end else begin
          sb_cnt_d = sb_cnt_q - SbW'(1);
        end
      end
      WaitSync: begin
        // abort beats sync, sync beats timeout
        if (!redundancy_en_i) begin
          state_d = Idle;
        end else if (synced) begin
          state_d = Idle;
          done_d  = 1'b1;
        end else if (timer_q == ToW'(TimeoutCycles - 1)) begin
          timeout_d = 1'b1;
          if (retry_q < RtW'(MaxRetries)) begin
            retry_d  = retry_q + RtW'(1);
            state_d  = Setback;
            sb_cnt_d = SbW'(SetbackCycles - 1);
          end else begin
            state_d = Failed;
          end
        end else begin
          timer_d = timer_q + ToW'(1);
        end
      end
      Failed: begin
        if (fail_clear_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= Idle;
      sb_cnt_q       <= '0;
      timer_q        <= '0;
      retry_q        <= '0;
      core_setback_o <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      timeout_o      <= 1'b0;
      fail_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sb_cnt_q       <= sb_cnt_d;
      timer_q        <= timer_d;
      retry_q        <= retry_d;
      core_setback_o <= {NumHarts{state_d == Setback}};
      busy_o         <= (state_d == Setback) ||
                        (state_d == WaitSync);
      done_o         <= done_d;
      timeout_o      <= timeout_d;
      fail_o         <= state_d == Failed;
    end
  end

  // clear wins over a coincident edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      err_prev_q <= err_or;
      if (cnt_clear_i) begin
        cnt_q <= '0;
      end else if (err_edge && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CntWidth'(1);
      end
    end
  end

  assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_cva6_dmr_resync_ctrl.sv
// Vector/scoreboard bench for cva6_dmr_resync_ctrl
// (SetbackCycles=4, TimeoutCycles=16, MaxRetries=1, CntWidth=2).
module tb_cva6_dmr_resync_ctrl;

  typedef struct packed {
    logic [1:0] sb;
    logic       busy;
    logic       done;
    logic       to;
    logic       fail;
    logic [1:0] cnt;
  } out_t;

  typedef struct packed {
    logic       en;
    logic [1:0] err;
    logic       sw;
    logic [1:0] sync;
    logic       fclr;
    logic       cclr;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] err;
  logic       sw;
  logic [1:0] sync;
  logic       fclr;
  logic       cclr;
  logic [1:0] setback;
  logic       busy;
  logic       done;
  logic       timeout;
  logic       fail;
  logic [1:0] err_cnt;

  out_t expq[$];
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[13];

  cva6_dmr_resync_ctrl #(
    .NumHarts(2),
    .SetbackCycles(4),
    .TimeoutCycles(16),
    .MaxRetries(1),
    .CntWidth(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .redundancy_en_i(en),
    .dmr_error_i(err),
    .sw_resync_req_i(sw),
    .harts_sync_req_i(sync),
    .fail_clear_i(fclr),
    .cnt_clear_i(cclr),
    .core_setback_o(setback),
    .busy_o(busy),
    .done_o(done),
    .timeout_o(timeout),
    .fail_o(fail),
    .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input int i_en, input int i_err, input int i_sw,
    input int i_sync, input int i_fclr, input int i_cclr,
    input int o_sb, input int o_busy, input int o_done,
    input int o_to, input int o_fail, input int o_cnt);
    vec_t r;
    r.en       = 1'(i_en);
    r.err      = 2'(i_err);
    r.sw       = 1'(i_sw);
    r.sync     = 2'(i_sync);
    r.fclr     = 1'(i_fclr);
    r.cclr     = 1'(i_cclr);
    r.exp.sb   = {2{1'(o_sb)}};
    r.exp.busy = 1'(o_busy);
    r.exp.done = 1'(o_done);
    r.exp.to   = 1'(o_to);
    r.exp.fail = 1'(o_fail);
    r.exp.cnt  = 2'(o_cnt);
    return r;
  endfunction

  task automatic check(input string nm);
    out_t act;
    out_t e;
    act = {setback, busy, done, timeout, fail, err_cnt};
    n_vec++;
    if (expq.size() == 0) begin
      n_err++;
      $display("FAIL %s #%0d: no expected entry queued", nm, n_vec);
    end else begin
      e = expq.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL %s #%0d: got sb=%b busy=%b done=%b to=%b fail=%b cnt=%0d, want sb=%b busy=%b done=%b to=%b fail=%b cnt=%0d",
                 nm, n_vec, act.sb, act.busy, act.done, act.to,
                 act.fail, act.cnt, e.sb, e.busy, e.done, e.to,
                 e.fail, e.cnt);
      end
    end
  endtask

  task automatic step(input string nm, input vec_t x);
    @(negedge clk);
    en   = x.en;
    err  = x.err;
    sw   = x.sw;
    sync = x.sync;
    fclr = x.fclr;
    cclr = x.cclr;
    expq.push_back(x.exp);
    @(posedge clk);
    #1;
    check(nm);
  endtask

  task automatic sb_phase(input string nm, input int sy,
                          input int c, input int n);
    repeat (n) step(nm, mk(1, 0, 0, sy, 0, 0, 1, 1, 0, 0, 0, c));
  endtask

  task automatic wait_phase(input string nm, input int sy,
                            input int c, input int n);
    repeat (n) step(nm, mk(1, 0, 0, sy, 0, 0, 0, 1, 0, 0, 0, c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1);
    tbl[6]  = mk(1, 0, 0, 3, 0, 0,  0, 0, 1, 0, 0, 1);
    tbl[7]  = mk(1, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 1);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    tbl[10] = mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    tbl[11] = mk(0, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2);
    tbl[12] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2);

    rst  = 1'b1;
    en   = 1'b0;
    err  = '0;
    sw   = 1'b0;
    sync = '0;
    fclr = 1'b0;
    cclr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expq.push_back('0);
    check("reset");
    @(negedge clk);
    rst = 1'b0;

    // basic resync, retrigger on done, abort, gating
    for (int i = 0; i < 13; i++) step("basic", tbl[i]);

    // retry then fail, sync stuck at 01
    step("rfail", mk(1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 2));
    sb_phase("rfail", 1, 2, 3);
    wait_phase("rfail", 1, 2, 16);
    step("rfail_to1", mk(1, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 2));
    sb_phase("rfail", 1, 2, 3);
    wait_phase("rfail", 1, 2, 16);
    step("rfail_to2", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 2));
    step("fail_trig", mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2));
    step("fail_clr", mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2));
    step("cclr_edge", mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step("cclr_after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // retry then succeed, sync 3 cycles into second wait
    step("rok", mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    sb_phase("rok", 0, 0, 3);
    wait_phase("rok", 0, 0, 16);
    step("rok_to", mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
    sb_phase("rok", 0, 0, 3);
    wait_phase("rok", 0, 0, 3);
    step("rok_done", mk(1, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0));
    step("rok_idle", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // sync in the timeout cycle
    step("tie", mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    sb_phase("tie", 0, 0, 3);
    wait_phase("tie", 0, 0, 16);
    step("tie_done", mk(1, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0));
    step("tie_idle", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // trigger during wait is dropped
    step("wtrig", mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    sb_phase("wtrig", 0, 0, 3);
    wait_phase("wtrig", 0, 0, 1);
    step("wtrig_req", mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    step("wtrig_done", mk(1, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0));
    step("wtrig_idle", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // counter saturation with redundancy off
    for (int i = 0; i < 5; i++) begin
      int c;
      c = (i + 1 > 3) ? 3 : i + 1;
      step("sat_hi", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c));
      step("sat_lo", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c));
    end

    // async reset mid-setback
    step("ar", mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 3));
    step("ar", mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3));
    #2;
    rst = 1'b1;
    #1;
    expq.push_back('0);
    check("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("ar_idle", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
